// File: rtl/crc_check.sv
// ---------------------------------------------------------------------------
// crc_check -- receive-side USB CRC checker
//
// Runs the serial CRC5 (token) or CRC16 (data) LFSR over every received bit,
// including the trailing CRC field. At end of packet it compares the LFSR
// with the fixed USB residual and reports pass/fail. Payload bits are
// forwarded downstream.
//
// Build option:
//   CRC_STRIP_EN  defined   -> a 16-bit delay line holds back the last N
//                              bits so the CRC field is never forwarded.
//                 undefined -> bits are forwarded unchanged (CRC included),
//                              zero latency.
//
// Ports:
//   clk       in  clock
//   rst_L     in  asynchronous active-low reset
//   start     in  one-cycle pulse before the first post-PID bit
//   pkttype   in  1 = CRC16 (data), 0 = CRC5 (token); sampled on start
//   inb       in  received bit after unstuffing
//   recving   in  high while body/CRC bits arrive; low ends the packet
//   pause_in  in  upstream stall, inb invalid this cycle
//   outb      out forwarded payload bit
//   sending   out outb valid this cycle
//   done      out one-cycle pulse, check complete
//   crc_ok    out residual matched (held until next start)
//   crc_err   out mismatch or runt packet (held until next start)
// ---------------------------------------------------------------------------
module crc_check (
  input  logic clk,
  input  logic rst_L,
  input  logic start,
  input  logic pkttype,
  input  logic inb,
  input  logic recving,
  input  logic pause_in,
  output logic outb,
  output logic sending,
  output logic done,
  output logic crc_ok,
  output logic crc_err
);

  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;
  localparam logic [4:0]  RES5   = 5'b01100;
  localparam logic [15:0] RES16  = 16'h800D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        crctype_r;
  logic [15:0] lfsr_r;
  logic [4:0]  cnt_r;
  logic        done_r;
  logic        crc_ok_r;
  logic        crc_err_r;

  logic        valid_s;
  logic [4:0]  n_s;
  logic        cnt_full_s;
  logic        match_s;

  // One serial LFSR step; in CRC5 mode only bits [4:0] are live.
  function automatic logic [15:0] crc_step(input logic [15:0] lfsr,
                                           input logic        bit_in,
                                           input logic        is16);
    logic        fb;
    logic [15:0] nxt;
    if (is16) begin
      fb  = bit_in ^ lfsr[15];
      nxt = {lfsr[14:0], 1'b0} ^ (fb ? POLY16 : 16'h0000);
    end else begin
      fb  = bit_in ^ lfsr[4];
      nxt = {11'd0, lfsr[3:0], 1'b0} ^ {11'd0, (fb ? POLY5 : 5'b00000)};
    end
    return nxt;
  endfunction

  // Residual comparison over the active width only.
  function automatic logic residual_ok(input logic [15:0] lfsr,
                                       input logic        is16);
    logic ok;
    if (is16) begin
      ok = (lfsr == RES16);
    end else begin
      ok = (lfsr[4:0] == RES5);
    end
    return ok;
  endfunction

  assign n_s        = crctype_r ? 5'd16 : 5'd5;
  assign cnt_full_s = (cnt_r == n_s);
  assign match_s    = cnt_full_s && residual_ok(lfsr_r, crctype_r);
  // A start cycle reinitialises, so any bit presented with it is discarded.
  assign valid_s    = (state_r == RECV) && recving && !pause_in && !start;

  // State register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start aborts and restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (start) begin
      state_nxt_s = RECV;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        RECV:    state_nxt_s = recving ? RECV : REPORT;
        REPORT:  state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // LFSR, bit counter and packet type.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      crctype_r <= 1'b0;
      lfsr_r    <= 16'hFFFF;
      cnt_r     <= 5'd0;
    end else if (start) begin
      crctype_r <= pkttype;
      lfsr_r    <= 16'hFFFF;
      cnt_r     <= 5'd0;
    end else if (valid_s) begin
      lfsr_r <= crc_step(lfsr_r, inb, crctype_r);
      if (!cnt_full_s) begin
        cnt_r <= cnt_r + 5'd1;
      end
    end
  end

  // Registered result flags; done is a single-cycle pulse out of REPORT.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      done_r    <= 1'b0;
      crc_ok_r  <= 1'b0;
      crc_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        crc_ok_r  <= 1'b0;
        crc_err_r <= 1'b0;
      end else if (state_r == REPORT) begin
        done_r    <= 1'b1;
        crc_ok_r  <= match_s;
        crc_err_r <= !match_s;
      end
    end
  end

  assign done    = done_r;
  assign crc_ok  = crc_ok_r;
  assign crc_err = crc_err_r;

`ifdef CRC_STRIP_EN
  logic [15:0] dly_r;
  logic        tap_s;

  // Delay line: every valid bit enters; the tap is the bit N valid bits back.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      dly_r <= 16'h0000;
    end else if (start) begin
      dly_r <= 16'h0000;
    end else if (valid_s) begin
      dly_r <= {dly_r[14:0], inb};
    end
  end

  assign tap_s = crctype_r ? dly_r[15] : dly_r[4];

  // Forward only once N bits are buffered, which holds back the CRC field.
  always_comb begin
    sending = 1'b0;
    outb    = 1'b0;
    if (valid_s && cnt_full_s) begin
      sending = 1'b1;
      outb    = tap_s;
    end else begin
      sending = 1'b0;
      outb    = 1'b0;
    end
  end
`else
  // Pass-through forwarding, CRC bits included.
  always_comb begin
    sending = 1'b0;
    outb    = 1'b0;
    if (valid_s) begin
      sending = 1'b1;
      outb    = inb;
    end else begin
      sending = 1'b0;
      outb    = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_crc_check.sv
// ---------------------------------------------------------------------------
// tb_crc_check -- self-checking bench for crc_check.
// Reference: a packet is good iff it has at least N bits and its last N bits
// equal the complement of the CRC remainder of the preceding bits, sent MSB
// first. Forwarded stream is the payload (strip build) or every bit.
// ---------------------------------------------------------------------------
module tb_crc_check;

  logic clk = 1'b0;
  logic rst_L;
  logic start;
  logic pkttype;
  logic inb;
  logic recving;
  logic pause_in;
  logic outb;
  logic sending;
  logic done;
  logic crc_ok;
  logic crc_err;

  int n_checks = 0;
  int n_errors = 0;

  bit got_q[$];
  int pause_viol;

  crc_check dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .start    (start),
    .pkttype  (pkttype),
    .inb      (inb),
    .recving  (recving),
    .pause_in (pause_in),
    .outb     (outb),
    .sending  (sending),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC remainder (register contents) over the first k bits, init all ones.
  function automatic int model_rem(input bit is16, input bit q[$], input int k);
    int w    = is16 ? 16 : 5;
    int poly = is16 ? 'h8005 : 'h05;
    int mask = (1 << w) - 1;
    int r    = mask;
    for (int i = 0; i < k; i++) begin
      int fb = int'(q[i]) ^ ((r >> (w - 1)) & 1);
      r = ((r << 1) & mask) ^ (fb != 0 ? poly : 0);
    end
    return r;
  endfunction

  function automatic bit model_ok(input bit is16, input bit q[$]);
    int w = is16 ? 16 : 5;
    int mask = (1 << w) - 1;
    int field = 0;
    int rem;
    if (q.size() < w) return 1'b0;
    rem = model_rem(is16, q, q.size() - w);
    for (int i = 0; i < w; i++) field = (field << 1) | int'(q[q.size() - w + i]);
    return field == (~rem & mask);
  endfunction

  // Payload followed by the correct CRC field.
  function automatic void add_crc(input bit is16, inout bit q[$]);
    int w = is16 ? 16 : 5;
    int mask = (1 << w) - 1;
    int fld = ~model_rem(is16, q, q.size()) & mask;
    for (int i = w - 1; i >= 0; i--) q.push_back(bit'((fld >> i) & 1));
  endfunction

  task automatic sample_out();
    #1;
    if (sending === 1'b1) begin
      got_q.push_back(outb);
      if (pause_in) pause_viol++;
    end
  endtask

  task automatic drive_start(input bit t);
    @(negedge clk);
    start = 1'b1; pkttype = t; recving = 1'b0; pause_in = 1'b0; inb = 1'b0;
    got_q.delete();
    pause_viol = 0;
  endtask

  // Bits with optional forced stall (npause cycles before bit pause_at)
  // and random stalls at pct percent.
  task automatic drive_bits(input bit q[$], input int pause_at, input int npause,
                            input int pct);
    for (int i = 0; i < q.size(); i++) begin
      int np = (i == pause_at) ? npause : 0;
      if ($urandom_range(99) < pct) np += 1;
      for (int p = 0; p < np; p++) begin
        @(negedge clk);
        start = 1'b0; recving = 1'b1; pause_in = 1'b1; inb = 1'b1;
        sample_out();
      end
      @(negedge clk);
      start = 1'b0; recving = 1'b1; pause_in = 1'b0; inb = q[i];
      sample_out();
    end
  endtask

  task automatic finish_pkt(input string tag, input bit is16, input bit q[$],
                            input bit chain, input bit ntype);
    bit exp_ok = model_ok(is16, q);
    int w = is16 ? 16 : 5;
    int ne;
`ifdef CRC_STRIP_EN
    ne = (q.size() > w) ? q.size() - w : 0;
`else
    ne = q.size();
`endif
    @(negedge clk);
    start = 1'b0; recving = 1'b0; pause_in = 1'(($urandom) & 1); inb = 1'(($urandom) & 1);
    #1;
    check_val({tag, ".end_send"}, {30'd0, sending, done}, 32'd0);
    @(negedge clk);
    #1;
    check_val({tag, ".report"}, {30'd0, sending, done}, 32'd0);
    @(negedge clk);
    #1;
    check_val({tag, ".done"}, {29'd0, done, crc_ok, crc_err}, {29'd0, 1'b1, exp_ok, !exp_ok});
    check_val({tag, ".nsend"}, got_q.size(), ne);
    for (int i = 0; i < ne && i < got_q.size(); i++)
      check_val({tag, ".outb"}, {31'd0, got_q[i]}, {31'd0, q[i]});
    check_val({tag, ".pause_send"}, pause_viol, 0);
    if (chain) begin
      start = 1'b1; pkttype = ntype;
    end
    @(negedge clk);
    if (chain) begin
      start = 1'b0; recving = 1'b1; pause_in = 1'b1; inb = 1'b1;
      got_q.delete();
      pause_viol = 0;
      #1;
      check_val({tag, ".chain_clr"}, {29'd0, done, crc_ok, crc_err}, 32'd0);
    end else begin
      #1;
      check_val({tag, ".hold"}, {29'd0, done, crc_ok, crc_err}, {29'd0, 1'b0, exp_ok, !exp_ok});
    end
  endtask

  initial begin
    bit q[$];
    bit junk[$];
    bit chained;
    bit t;
    bit next_t;
    bit ch;
    rst_L = 1'b0; start = 1'b0; pkttype = 1'b0; inb = 1'b0;
    recving = 1'b0; pause_in = 1'b0;
    #12;
    check_val("reset", {27'd0, outb, sending, done, crc_ok, crc_err}, 32'd0);
    @(negedge clk);
    rst_L = 1'b1;

    // CRC5 good token: 11 zeros then 0,1,0,0,0.
    q = {};
    for (int i = 0; i < 11; i++) q.push_back(1'b0);
    q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b0); q.push_back(1'b0);
    drive_start(1'b0); drive_bits(q, -1, 0, 0); finish_pkt("tok5", 1'b0, q, 1'b0, 1'b0);

    // Corrupted bit 3.
    junk = q; junk[3] = ~junk[3];
    drive_start(1'b0); drive_bits(junk, -1, 0, 0); finish_pkt("tok5_bad", 1'b0, junk, 1'b0, 1'b0);

    // Stall of 3 cycles mid-token.
    drive_start(1'b0); drive_bits(q, 6, 3, 0); finish_pkt("tok5_stall", 1'b0, q, 1'b0, 1'b0);

    // CRC16 zero-length data.
    junk = {};
    for (int i = 0; i < 16; i++) junk.push_back(1'b0);
    drive_start(1'b1); drive_bits(junk, -1, 0, 0); finish_pkt("dat0", 1'b1, junk, 1'b0, 1'b0);

    // Runt CRC16 packet.
    junk = {};
    for (int i = 0; i < 10; i++) junk.push_back(1'(($urandom) & 1));
    drive_start(1'b1); drive_bits(junk, -1, 0, 0); finish_pkt("runt", 1'b1, junk, 1'b0, 1'b0);

    // Abort: restart mid-packet with a good token.
    junk = {};
    for (int i = 0; i < 5; i++) junk.push_back(1'(($urandom) & 1));
    drive_start(1'b1); drive_bits(junk, -1, 0, 0);
    drive_start(1'b0); drive_bits(q, -1, 0, 0); finish_pkt("abort", 1'b0, q, 1'b0, 1'b0);

    // Reset mid-RECV.
    drive_start(1'b1); drive_bits(junk, -1, 0, 0);
    @(negedge clk);
    inb = 1'b1; recving = 1'b1; pause_in = 1'b0;
    #2 rst_L = 1'b0;
    #1;
    check_val("rst_mid", {27'd0, outb, sending, done, crc_ok, crc_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("rst_nodone", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_L = 1'b1; recving = 1'b0;
    drive_start(1'b0); drive_bits(q, -1, 0, 0); finish_pkt("post_rst", 1'b0, q, 1'b0, 1'b0);

    // Randomised packets, some chained with start coincident with done.
    chained = 1'b0;
    next_t  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int mode = $urandom_range(3);
      t = chained ? next_t : 1'(($urandom) & 1);
      q = {};
      if (mode == 3) begin
        int len = $urandom_range(t ? 15 : 4);
        for (int i = 0; i < len; i++) q.push_back(1'(($urandom) & 1));
      end else begin
        int len = $urandom_range(t ? 24 : 12);
        for (int i = 0; i < len; i++) q.push_back(1'(($urandom) & 1));
        add_crc(t, q);
        if (mode == 2) begin
          int k = $urandom_range(q.size() - 1);
          q[k] = ~q[k];
        end
      end
      if (!chained) drive_start(t);
      drive_bits(q, -1, 0, 25);
      ch = (n < 39) && ($urandom_range(2) == 0);
      next_t = 1'(($urandom) & 1);
      finish_pkt("rand", t, q, ch, next_t);
      chained = ch;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side CRC checker for the USB bit pipeline; sits after NRZI decode and bit unstuffing and before packet disassembly. It runs the serial CRC5 (tokens) or CRC16 (data) LFSR over every received bit, including the trailing CRC field. At end of packet it compares the LFSR against the fixed USB residual and reports pass or fail. It forwards payload bits downstream with the CRC field stripped off.

## Interface
- No parameters; CRC width (5 or 16) is selected per packet by `pkttype`.
- `clk` in 1: clock.
- `rst_L` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse, one cycle before the first post-PID bit; latches `pkttype` and initialises the checker.
- `pkttype` in 1: 1 = CRC16 (data packet), 0 = CRC5 (token); sampled only when `start`=1.
- `inb` in 1: received bit after unstuffing.
- `recving` in 1: high while body and CRC bits arrive; falling edge marks end of packet.
- `pause_in` in 1: upstream stall (stuffed bit removed); `inb` is invalid this cycle.
- `outb` out 1: forwarded payload bit.
- `sending` out 1: `outb` valid this cycle.
- `done` out 1: one-cycle pulse, check complete.
- `crc_ok` out 1: residual matched; valid from `done`, held until next `start`.
- `crc_err` out 1: residual mismatch or runt packet; valid from `done`, held until next `start`.

## Operation
- FSM states: IDLE, RECV, REPORT.
  - IDLE -> RECV on `start`.
  - RECV -> REPORT on `recving`=0 sampled in RECV.
  - REPORT -> IDLE unconditionally after 1 cycle.
- On `start`: latch `crctype`=`pkttype`, set LFSR to all ones, clear bit count, clear `crc_ok`/`crc_err`.
  - `start` in any state, including mid-RECV, aborts the current packet and reinitialises.
- A bit is valid when state=RECV, `recving`=1, and `pause_in`=0. On each valid bit:
  - `fb` = `inb` ^ `lfsr[msb]`
  - `lfsr` = (`lfsr` << 1) ^ (`fb` ? poly : 0)
  - CRC5: poly 5'b00101, width 5. CRC16: poly 16'h8005, width 16. Bits above the active width are ignored.
- Bit count `cnt` (5 bits) increments per valid bit and saturates at N (N = 5 for CRC5, 16 for CRC16).
- Delay line: a 16-bit shift register accepts every valid bit. Once `cnt`==N before the shift, each valid bit also emits the bit N positions earlier on `outb` with `sending`=1.
  - Net effect: the last N bits of the packet (the CRC field) are never forwarded.
- REPORT:
  - `done`=1 for one cycle.
  - `crc_ok`=1 iff `cnt`==N and the LFSR equals the residual: CRC5 5'b01100, CRC16 16'h800D.
  - Otherwise `crc_err`=1.
- `recving`=0 or `pause_in`=1 while in IDLE is ignored. A `pause_in` during RECV freezes the LFSR, counter and delay line.
- Reset: state IDLE, LFSR all ones, `cnt`=0, delay line 0. Outputs `outb`, `sending`, `done`, `crc_ok`, `crc_err` are all 0.
  - Reset mid-packet discards the packet without raising `done`.

## Timing
- Inputs are sampled on posedge `clk`. `outb`/`sending` are combinational from the delay-line tap and the current-cycle valid bit, so there is zero added cycle latency; bit latency is N valid bits.
- `done`, `crc_ok` and `crc_err` are registered. `done` rises exactly one cycle after the edge that samples `recving`=0 in RECV.
- `sending` is never asserted in IDLE or REPORT, and never on a `pause_in` cycle.
- `start` coincident with `done` is honoured: the next packet is initialised and `crc_ok`/`crc_err` clear on the following edge.

## Configuration
- `CRC_STRIP_EN` defined: the delay line is present and the CRC field is stripped, as described above.
- `CRC_STRIP_EN` undefined: the delay line is removed; `outb`=`inb` and `sending`=valid bit, with zero latency, and the CRC bits are forwarded. The checking and `done`/`crc_ok`/`crc_err` behaviour is unchanged.

## Test plan
- CRC5 good token: `start` with `pkttype`=0, 11 zeros then CRC bits 0,1,0,0,0 -> `done` pulse, `crc_ok`=1, `crc_err`=0. With `CRC_STRIP_EN`, exactly 11 `sending` cycles, all `outb`=0.
- CRC16 zero-length data: `pkttype`=1, 16 zero bits -> `crc_ok`=1, and 0 `sending` cycles with `CRC_STRIP_EN`.
- Corruption: the CRC5 token above with bit 3 flipped -> `crc_err`=1, `crc_ok`=0.
- Stall: the CRC5 token with `pause_in` high for 3 cycles (`inb`=1 on those cycles) -> result unchanged (`crc_ok`=1), and no `sending` on paused cycles.
- Runt and abort: `pkttype`=1 with only 10 bits -> `crc_err`=1. A new `start` mid-packet followed by a valid CRC5 token -> `crc_ok`=1.
- Reset: `rst_L` low mid-RECV -> all outputs 0 immediately and no `done`. The next packet checks correctly.
